// File: rtl/usb_kbd_led_ctrl.sv
// Keyboard lock-LED controller: tracks Num/Caps/Scroll lock from HID reports and
// software overrides, and pushes coalesced, rate-limited LED updates over a 4-phase req/ack.
module usb_kbd_led_ctrl #(
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int GAP_CYCLES     = 1200
) (
  input  logic       usb_clk,
  input  logic       usb_rst_n,
  input  logic [1:0] typ,
  input  logic       report,
  input  logic [7:0] key1,
  input  logic [7:0] key2,
  input  logic [7:0] key3,
  input  logic [7:0] key4,
  input  logic       sw_wr,
  input  logic [2:0] sw_leds,
  input  logic       led_ack,
  output logic [7:0] leds,
  output logic       led_req,
  output logic [2:0] led_state,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [7:0]  NUM_CODE    = 8'h53;
  localparam logic [7:0]  CAPS_CODE   = 8'h39;
  localparam logic [7:0]  SCROLL_CODE = 8'h47;
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] GAP_LEN     = 17'(GAP_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, REL, GAP} state_t;

  state_t      state;
  logic [15:0] timer;
  logic [2:0]  prev;
  logic [2:0]  snapshot;
  logic        pending;
  logic        kbd_q;

  logic        is_kbd;
  logic [2:0]  present;
  logic [2:0]  rise;
  logic [2:0]  led_next;
  logic        chg_event;

  function automatic logic key_hit(input logic [7:0] code, input logic [7:0] k1,
                                   input logic [7:0] k2, input logic [7:0] k3,
                                   input logic [7:0] k4);
    return (k1 == code) || (k2 == code) || (k3 == code) || (k4 == code);
  endfunction

  assign is_kbd   = (typ == 2'd1);
  assign present  = {key_hit(SCROLL_CODE, key1, key2, key3, key4),
                     key_hit(CAPS_CODE,   key1, key2, key3, key4),
                     key_hit(NUM_CODE,    key1, key2, key3, key4)};
  assign rise     = (report && is_kbd) ? (present & ~prev) : 3'b000;
  // Toggles land on top of an override written in the same cycle.
  assign led_next = (sw_wr ? sw_leds : led_state) ^ rise;
  assign chg_event = (led_next != led_state) || sw_wr || (is_kbd && !kbd_q);
  assign leds     = {5'b00000, snapshot};

  always_ff @(posedge usb_clk or negedge usb_rst_n) begin
    if (!usb_rst_n) begin
      state       <= IDLE;
      timer       <= 16'd0;
      prev        <= 3'b000;
      snapshot    <= 3'b000;
      pending     <= 1'b0;
      led_state   <= 3'b000;
      led_req     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      // A keyboard already attached at reset is not treated as a fresh connection.
      kbd_q       <= 1'b1;
    end else begin
      led_state   <= led_next;
      kbd_q       <= is_kbd;
      timeout_err <= 1'b0;

      if (typ == 2'd0)
        prev <= 3'b000;
      else if (report && is_kbd)
        prev <= present;

      case (state)
        IDLE: begin
          if (pending && is_kbd) begin
            snapshot <= led_state;
            pending  <= 1'b0;
            timer    <= 16'd0;
            led_req  <= 1'b1;
            busy     <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (led_ack) begin
            led_req <= 1'b0;
            state   <= REL;
          end else if (timer == TO_LAST) begin
            timeout_err <= 1'b1;
            pending     <= 1'b1;
            led_req     <= 1'b0;
            state       <= REL;
          end else if (!is_kbd) begin
            led_req <= 1'b0;
            state   <= REL;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        REL: begin
          if (!led_ack) begin
            timer <= 16'd0;
            state <= GAP;
          end
        end
        GAP: begin
          if (({1'b0, timer} + 17'd1) >= GAP_LEN) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Later assignments win: new events re-arm pending, a detached device clears it.
      if (chg_event)
        pending <= 1'b1;
      if (typ == 2'd0)
        pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_kbd_led_ctrl.sv
// Self-checking bench for usb_kbd_led_ctrl: directed scenarios plus a randomized run
// against a report-level lock-state model and an automatic host responder.
module tb_usb_kbd_led_ctrl;
  localparam int TO  = 16;
  localparam int GAP = 1200;

  logic       usb_clk = 1'b0;
  logic       usb_rst_n;
  logic [1:0] typ;
  logic       report;
  logic [7:0] key1, key2, key3, key4;
  logic       sw_wr;
  logic [2:0] sw_leds;
  logic       led_ack;
  logic [7:0] leds;
  logic       led_req;
  logic [2:0] led_state;
  logic       busy;
  logic       timeout_err;

  int n_chk = 0;
  int n_fail = 0;

  logic [2:0] m_led, m_prev;
  bit         auto_ack = 1'b0;
  logic       host_ack = 1'b0;
  logic       man_ack = 1'b0;
  int         ack_dly = 0;

  assign led_ack = auto_ack ? host_ack : man_ack;

  usb_kbd_led_ctrl #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .usb_clk(usb_clk), .usb_rst_n(usb_rst_n), .typ(typ), .report(report),
    .key1(key1), .key2(key2), .key3(key3), .key4(key4),
    .sw_wr(sw_wr), .sw_leds(sw_leds), .led_ack(led_ack),
    .leds(leds), .led_req(led_req), .led_state(led_state),
    .busy(busy), .timeout_err(timeout_err));

  always #5 usb_clk = ~usb_clk;

  // Host model: acknowledges each request after a short random delay.
  always @(negedge usb_clk) begin
    if (led_req && !host_ack) begin
      if (ack_dly == 0) host_ack = 1'b1;
      else ack_dly--;
    end else if (!led_req && host_ack) begin
      host_ack = 1'b0;
    end else if (!led_req) begin
      ack_dly = $urandom_range(0, 4);
    end
  end

  function automatic logic has(input logic [7:0] c);
    return (key1 == c) || (key2 == c) || (key3 == c) || (key4 == c);
  endfunction

  // One clock: update the lock-state model from the inputs held over the edge,
  // clear one-cycle strobes, and return at the next falling edge for sampling.
  task automatic cyc();
    logic [2:0] pres, t;
    pres = {has(8'h47), has(8'h39), has(8'h53)};
    t = 3'b000;
    if (typ == 2'd0) m_prev = 3'b000;
    else if (report && typ == 2'd1) begin
      t = pres & ~m_prev;
      m_prev = pres;
    end
    @(posedge usb_clk);
    m_led = (sw_wr ? sw_leds : m_led) ^ t;
    #1;
    report = 1'b0;
    sw_wr = 1'b0;
    @(negedge usb_clk);
  endtask

  task automatic run_count(input int n, output int rises);
    logic q;
    q = led_req;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (led_req && !q) rises++;
      q = led_req;
    end
  endtask

  task automatic do_reset();
    usb_rst_n = 1'b0;
    typ = 2'd1; report = 1'b0; sw_wr = 1'b0; sw_leds = 3'b000;
    key1 = 8'h00; key2 = 8'h00; key3 = 8'h00; key4 = 8'h00;
    auto_ack = 1'b0; man_ack = 1'b0;
    m_led = 3'b000; m_prev = 3'b000;
    repeat (3) @(negedge usb_clk);
    usb_rst_n = 1'b1;
    @(negedge usb_clk);
  endtask

  task automatic test_reset();
    int r;
    do_reset();
    n_chk++; if (leds !== 8'h00) begin n_fail++; $display("FAIL reset_leds: got %h want 00", leds); end
    n_chk++; if (led_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", led_req); end
    n_chk++; if (led_state !== 3'b000) begin n_fail++; $display("FAIL reset_state: got %b want 000", led_state); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
    run_count(20, r);
    n_chk++; if (r != 0) begin n_fail++; $display("FAIL reset_idle_req: got %0d requests want 0", r); end
  endtask

  task automatic test_caps();
    int bad;
    do_reset();
    key1 = 8'h39; report = 1'b1;
    cyc();
    n_chk++; if (led_state !== 3'b010) begin n_fail++; $display("FAIL caps_state: got %b want 010", led_state); end
    n_chk++; if (led_req !== 1'b0) begin n_fail++; $display("FAIL caps_req_t1: got %b want 0", led_req); end
    cyc();
    n_chk++; if (led_req !== 1'b1) begin n_fail++; $display("FAIL caps_req_t2: got %b want 1", led_req); end
    n_chk++; if (leds !== 8'h02) begin n_fail++; $display("FAIL caps_leds: got %h want 02", leds); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL caps_busy: got %b want 1", busy); end
    cyc(); cyc();
    man_ack = 1'b1;
    cyc();
    n_chk++; if (led_req !== 1'b0) begin n_fail++; $display("FAIL caps_req_drop: got %b want 0", led_req); end
    cyc();
    man_ack = 1'b0;
    cyc();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL caps_gap_busy: got %b want 1", busy); end
    bad = 0;
    for (int i = 0; i < GAP - 1; i++) begin
      cyc();
      if (busy !== 1'b1 || led_req !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL caps_gap_len: %0d early-idle cycles want 0", bad); end
    cyc();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL caps_gap_end: got busy %b want 0", busy); end
  endtask

  task automatic test_held_key();
    logic [7:0] ktab [5] = '{8'h39, 8'h39, 8'h39, 8'h04, 8'h39};
    logic [2:0] etab [5] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key2 = ktab[i]; report = 1'b1;
      cyc();
      n_chk++;
      if (led_state !== etab[i]) begin
        n_fail++; $display("FAIL held_key_%0d: got %b want %b", i, led_state, etab[i]);
      end
      repeat (3) cyc();
    end
  endtask

  task automatic test_coalesce();
    int n, r;
    do_reset();
    sw_leds = 3'b000; sw_wr = 1'b1;
    cyc(); cyc();
    n_chk++; if (led_req !== 1'b1 || leds !== 8'h00) begin n_fail++; $display("FAIL coal_first: req %b leds %h want 1 00", led_req, leds); end
    key1 = 8'h53; report = 1'b1;
    cyc();
    man_ack = 1'b1; cyc();
    man_ack = 1'b0; cyc();
    key1 = 8'h47; report = 1'b1;
    cyc();
    n_chk++; if (led_state !== 3'b101) begin n_fail++; $display("FAIL coal_state: got %b want 101", led_state); end
    n = 0;
    while (!led_req && n < GAP + 100) begin cyc(); n++; end
    n_chk++; if (led_req !== 1'b1 || leds !== 8'h05) begin n_fail++; $display("FAIL coal_second: req %b leds %h want 1 05", led_req, leds); end
    auto_ack = 1'b1;
    run_count(2 * GAP + 200, r);
    n_chk++; if (r != 0) begin n_fail++; $display("FAIL coal_extra: got %0d more requests want 0", r); end
  endtask

  task automatic test_sw_and_report();
    int r;
    do_reset();
    sw_leds = 3'b111; sw_wr = 1'b1; key1 = 8'h53; report = 1'b1;
    cyc();
    n_chk++; if (led_state !== 3'b110) begin n_fail++; $display("FAIL swrep_state: got %b want 110", led_state); end
    cyc();
    n_chk++; if (led_req !== 1'b1 || leds !== 8'h06) begin n_fail++; $display("FAIL swrep_req: req %b leds %h want 1 06", led_req, leds); end
    auto_ack = 1'b1;
    run_count(2 * GAP + 200, r);
    n_chk++; if (r != 0) begin n_fail++; $display("FAIL swrep_extra: got %0d more requests want 0", r); end
  endtask

  task automatic test_timeout();
    int hi, n;
    do_reset();
    sw_leds = 3'b011; sw_wr = 1'b1;
    cyc(); cyc();
    hi = 0;
    while (led_req && hi < 100) begin
      n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early_err: got %b want 0", timeout_err); end
      hi++; cyc();
    end
    n_chk++; if (hi != TO) begin n_fail++; $display("FAIL to_req_len: got %0d cycles want %0d", hi, TO); end
    n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_err_pulse: got %b want 1", timeout_err); end
    cyc();
    n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_err_width: got %b want 0", timeout_err); end
    n = 0;
    while (!led_req && n < GAP + 100) begin cyc(); n++; end
    n_chk++; if (led_req !== 1'b1 || leds !== 8'h03) begin n_fail++; $display("FAIL to_retry: req %b leds %h want 1 03", led_req, leds); end
    n_chk++; if (n < GAP) begin n_fail++; $display("FAIL to_retry_gap: retry after %0d cycles want >= %0d", n, GAP); end
  endtask

  task automatic test_reconnect();
    int r;
    do_reset();
    auto_ack = 1'b1;
    key1 = 8'h39; report = 1'b1;
    run_count(GAP + 100, r);
    n_chk++; if (r != 1) begin n_fail++; $display("FAIL recon_first: got %0d requests want 1", r); end
    typ = 2'd0;
    sw_leds = 3'b010; sw_wr = 1'b1;
    run_count(50, r);
    n_chk++; if (r != 0) begin n_fail++; $display("FAIL recon_detached: got %0d requests want 0", r); end
    n_chk++; if (led_state !== 3'b010) begin n_fail++; $display("FAIL recon_kept: got %b want 010", led_state); end
    typ = 2'd1;
    cyc();
    n_chk++; if (led_req !== 1'b0) begin n_fail++; $display("FAIL recon_req_t1: got %b want 0", led_req); end
    cyc();
    n_chk++; if (led_req !== 1'b1 || leds !== 8'h02) begin n_fail++; $display("FAIL recon_req: req %b leds %h want 1 02", led_req, leds); end
    do_reset();
    sw_leds = 3'b101; sw_wr = 1'b1;
    cyc(); cyc();
    n_chk++; if (led_req !== 1'b1 || leds !== 8'h05) begin n_fail++; $display("FAIL rst_pre: req %b leds %h want 1 05", led_req, leds); end
    #2 usb_rst_n = 1'b0;
    #1;
    n_chk++;
    if (led_req !== 1'b0 || leds !== 8'h00 || led_state !== 3'b000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: req %b leds %h state %b busy %b want all 0", led_req, leds, led_state, busy);
    end
    @(negedge usb_clk);
    usb_rst_n = 1'b1;
    m_led = 3'b000; m_prev = 3'b000;
    @(negedge usb_clk);
  endtask

  task automatic test_random();
    logic [7:0] pool [6] = '{8'h53, 8'h39, 8'h47, 8'h04, 8'h00, 8'h1e};
    logic [2:0] m_led_q;
    logic [7:0] leds_q;
    logic       req_q;
    int         r;
    do_reset();
    auto_ack = 1'b1;
    m_led_q = m_led; leds_q = leds; req_q = led_req;
    for (int i = 0; i < 9000; i++) begin
      n_chk++;
      if (led_state !== m_led) begin n_fail++; $display("FAIL rnd_state@%0d: got %b want %b", i, led_state, m_led); end
      if (led_req && !req_q) begin
        n_chk++;
        if (leds !== {5'b0, m_led_q}) begin n_fail++; $display("FAIL rnd_snapshot@%0d: got %h want %h", i, leds, {5'b0, m_led_q}); end
      end else if (leds !== leds_q) begin
        n_chk++; n_fail++; $display("FAIL rnd_leds_stable@%0d: got %h want %h", i, leds, leds_q);
      end
      m_led_q = m_led; leds_q = leds; req_q = led_req;
      if ($urandom_range(0, 999) == 0) typ = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        key1 = pool[$urandom_range(0, 5)]; key2 = pool[$urandom_range(0, 5)];
        key3 = pool[$urandom_range(0, 5)]; key4 = pool[$urandom_range(0, 5)];
        report = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) begin
        sw_leds = 3'($urandom_range(0, 7)); sw_wr = 1'b1;
      end
      cyc();
    end
    typ = 2'd1;
    run_count(3 * GAP + 300, r);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rnd_quiesce: busy %b want 0", busy); end
    n_chk++; if (leds !== {5'b0, m_led}) begin n_fail++; $display("FAIL rnd_final_leds: got %h want %h", leds, {5'b0, m_led}); end
  endtask

  initial begin
    test_reset();
    test_caps();
    test_held_key();
    test_coalesce();
    test_sw_and_report();
    test_timeout();
    test_reconnect();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_kbd_led_ctrl.md
# usb_kbd_led_ctrl

Keyboard lock-LED controller in the USB clock domain, sitting beside `usb_hid_host`. Watches keyboard reports for Num/Caps/Scroll Lock key presses, keeps the lock state, and schedules LED output-report updates to the host over a 4-phase req/ack handshake. Software can override the state; changes are coalesced and rate-limited so the host sees at most one update in flight.

## Interface
- `TIMEOUT_CYCLES`, 24000: max cycles in REQ waiting for ack (2 ms at 12 MHz); 1..65535.
- `GAP_CYCLES`, 1200: min idle cycles between completed transactions; 0..65535.

- `usb_clk` in 1: 12 MHz clock.
- `usb_rst_n` in 1: reset, asynchronous, active-low.
- `typ` in 2: device type from host; 1 = keyboard.
- `report` in 1: one-cycle pulse; key fields valid.
- `key1`..`key4` in 8 each: HID usage codes from last report.
- `sw_wr` in 1: one-cycle software override strobe.
- `sw_leds` in 3: override value {scroll, caps, num}.
- `led_ack` in 1: host acknowledge (4-phase).
- `leds` out 8: {5'b0, snapshot}; stable while `led_req`=1.
- `led_req` out 1: update request to host.
- `led_state` out 3: live lock state {scroll, caps, num}.
- `busy` out 1: FSM not IDLE.
- `timeout_err` out 1: one-cycle pulse on handshake timeout.

## Operation
- Lock codes: Num 0x53 (bit0), Caps 0x39 (bit1), Scroll 0x47 (bit2). Key "present" = any of key1..key4 equals code.
- On `report` with `typ`==1: per lock key, rising = present && !prev; `prev` <= present. Reports with `typ`!=1 ignored.
- Toggle vector T = rising bits. Update: `led_state` <= (sw_wr ? sw_leds : led_state) ^ T. Simultaneous `sw_wr` and report: toggles applied on top of override.
- `pending` set whenever `led_state` changes value, on `sw_wr` (even if same value), and on `typ` transition from !=1 to 1 (resync new keyboard).
- `typ`==0: `prev` cleared to 0; `led_state` retained; `pending` cleared.
- FSM states IDLE, REQ, REL, GAP:
  - IDLE: if `pending` && `typ`==1: snapshot <= led_state, pending <= 0, timer <= 0, -> REQ.
  - REQ: `led_req`=1. led_ack=1 -> REL. timer reaches TIMEOUT_CYCLES-1 without ack -> pulse `timeout_err`, pending <= 1, -> REL. `typ` leaves 1 -> REL (no error).
  - REL: `led_req`=0; wait `led_ack`=0, then timer <= 0 -> GAP.
  - GAP: count GAP_CYCLES cycles -> IDLE (GAP_CYCLES=0: one cycle in GAP).
- Changes during REQ/REL/GAP only set `pending`; coalesced into one next transaction carrying latest state.
- Timer 16-bit, saturating not required (bounded by params).

## Timing
- Reset: `led_state`=0, `prev`=0, `pending`=0, snapshot=0, `leds`=0, `led_req`=0, `busy`=0, `timeout_err`=0, FSM IDLE, timer 0.
- `report` at cycle t -> `led_state` updated t+1 -> `led_req` high t+2 (if IDLE, typ==1).
- `led_ack` rises at cycle a -> `led_req` low a+1. `led_ack` low at b -> GAP entered b+1; IDLE after GAP_CYCLES further cycles.
- `leds` changes only on IDLE->REQ transition.
- Timeout: `led_req` high exactly TIMEOUT_CYCLES cycles, `timeout_err` pulse in cycle `led_req` falls.
- Async reset mid-REQ: `led_req` drops immediately; state lost.

## Test plan
- Caps press: typ=1, report key1=0x39 -> led_state=3'b010, led_req at t+2, leds=8'h02; ack 3 cycles later -> req drops next cycle; release of ack -> GAP 1200 cycles then IDLE.
- Held key: three reports with key2=0x39, then one without, then one with -> toggles only on 1st and 5th: led_state 010, 010, 010, 010, 000.
- Coalescing: Num press during REQ and Scroll press during GAP -> exactly one further transaction with leds=8'h05 (from 000 state plus caps? start 000) after GAP.
- sw_wr sw_leds=3'b111 same cycle as report with key1=0x53 -> led_state=3'b110, one request with leds=8'h06.
- Timeout: never ack, TIMEOUT_CYCLES=16 -> led_req high 16 cycles, timeout_err pulse, retry request after GAP.
- Reconnect: typ 1->0->1 with led_state=3'b010 -> pending cleared at 0, new request leds=8'h02 on reconnect; reset asserted during REQ -> all outputs 0 asynchronously.
